// File: rtl/iram_pkg.sv
// Shared types and constants for the microcode SRAM write sequencer.
package iram_pkg;

    localparam int IRAM_ADDR_W    = 14;
    localparam int IRAM_DATA_W    = 49;

    // Default strobe timing, in clock cycles.
    localparam int IRAM_SETUP_CYC = 1;
    localparam int IRAM_PULSE_CYC = 2;
    localparam int IRAM_HOLD_CYC  = 1;
    localparam bit IRAM_VERIFY    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_VERIFY
    } iram_state_t;

    // The phase timer is loaded with (cycles - 1), so it only needs to hold
    // one less than the longest phase.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/iram_phase_timer.sv
// Loadable down-counter that times each strobe phase; tc is high while the
// count sits at zero, i.e. during the last cycle of the loaded phase.
module iram_phase_timer
    import iram_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/iram_loader.sv
// Write sequencer for the microcode SRAM: takes (address, word) requests,
// drives a setup / WE_N pulse / hold strobe sequence and optionally reads the
// word back to flag mismatches. Every output comes straight from a flop.
module iram_loader
    import iram_pkg::*;
#(
    parameter int ADDR_W    = IRAM_ADDR_W,
    parameter int DATA_W    = IRAM_DATA_W,
    parameter int SETUP_CYC = IRAM_SETUP_CYC,
    parameter int PULSE_CYC = IRAM_PULSE_CYC,
    parameter int HOLD_CYC  = IRAM_HOLD_CYC,
    parameter bit VERIFY    = IRAM_VERIFY
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic              busy,
    input  logic              err_clr,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       word_cnt
);

    localparam int CNT_W = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    iram_state_t       state, state_nxt;
    logic              in_ready_nxt, busy_nxt, ram_ce_n_nxt, ram_we_n_nxt;
    logic [ADDR_W-1:0] ram_a_nxt, err_addr_nxt;
    logic [DATA_W-1:0] ram_di_nxt, cmp_data, cmp_data_nxt;
    logic              err_nxt, verify_mismatch;
    logic [15:0]       word_cnt_nxt;
    logic              tmr_load, tmr_tc;
    logic [CNT_W-1:0]  tmr_val;

    iram_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // State and all RAM-facing / status outputs are registered together so
    // the strobes can never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            ram_ce_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_a    <= '0;
            ram_di   <= '0;
            cmp_data <= '0;
            err      <= 1'b0;
            err_addr <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= in_ready_nxt;
            busy     <= busy_nxt;
            ram_ce_n <= ram_ce_n_nxt;
            ram_we_n <= ram_we_n_nxt;
            ram_a    <= ram_a_nxt;
            ram_di   <= ram_di_nxt;
            cmp_data <= cmp_data_nxt;
            err      <= err_nxt;
            err_addr <= err_addr_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    // Phase sequencing: each phase loads the timer for the next one on exit,
    // and the error status is updated last so a mismatch overrides a clear.
    always_comb begin
        state_nxt       = state;
        in_ready_nxt    = in_ready;
        busy_nxt        = busy;
        ram_ce_n_nxt    = ram_ce_n;
        ram_we_n_nxt    = ram_we_n;
        ram_a_nxt       = ram_a;
        ram_di_nxt      = ram_di;
        cmp_data_nxt    = cmp_data;
        err_nxt         = err;
        err_addr_nxt    = err_addr;
        word_cnt_nxt    = word_cnt;
        tmr_load        = 1'b0;
        tmr_val         = '0;
        verify_mismatch = 1'b0;

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    ram_a_nxt    = in_addr;
                    ram_di_nxt   = in_data;
                    cmp_data_nxt = in_data;
                    ram_ce_n_nxt = 1'b0;
                    busy_nxt     = 1'b1;
                    in_ready_nxt = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_val      = SETUP_LD;
                    state_nxt    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_tc) begin
                    ram_we_n_nxt = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_val      = PULSE_LD;
                    state_nxt    = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (tmr_tc) begin
                    ram_we_n_nxt = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = HOLD_LD;
                    state_nxt    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_tc) begin
                    word_cnt_nxt = word_cnt + 16'd1;
                    if (VERIFY) begin
                        state_nxt = ST_VERIFY;
                    end else begin
                        ram_ce_n_nxt = 1'b1;
                        busy_nxt     = 1'b0;
                        in_ready_nxt = 1'b1;
                        state_nxt    = ST_IDLE;
                    end
                end
            end
            ST_VERIFY: begin
                verify_mismatch = (ram_do != cmp_data);
                ram_ce_n_nxt    = 1'b1;
                busy_nxt        = 1'b0;
                in_ready_nxt    = 1'b1;
                state_nxt       = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (err_clr) begin
            err_nxt      = 1'b0;
            err_addr_nxt = '0;
        end
        if (verify_mismatch) begin
            err_nxt = 1'b1;
            if (!err || err_clr) begin
                err_addr_nxt = ram_a;
            end
        end
    end

endmodule

// File: tb/tb_iram_loader.sv
// Bench for iram_loader: one default instance with read-back and one
// slow-setup instance without it, each driving its own behavioural SRAM.
module tb_iram_loader;

    localparam int S0 = 1, P0 = 2, H0 = 1, V0 = 1;
    localparam int S1 = 3, P1 = 1, H1 = 2, V1 = 0;
    localparam int VK0 = 1 + S0 + P0 + H0;

    logic        clk = 1'b0;
    logic [1:0]  rstN, inValid, inReady, ramCeN, ramWeN, busy, errClr, err;
    logic [13:0] inAddr [2];
    logic [13:0] ramA [2];
    logic [13:0] errAddr [2];
    logic [48:0] inData [2];
    logic [48:0] ramDi [2];
    logic [48:0] ramDo [2];
    logic [15:0] wordCnt [2];

    logic [48:0] mem0 [16384];
    logic [48:0] mem1 [16384];
    bit          badBit [16384];
    int          rise0 = 0;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;

    logic [15:0] cntM [2];
    logic        errM;
    logic [13:0] errAddrM;
    logic [48:0] expMem0 [int];
    logic [48:0] expMem1 [int];

    always #5 clk = ~clk;

    // Free-running cycle count for measuring acceptance spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM 0 commits on the rising edge of WE_N and can be told to corrupt reads.
    always @(posedge ramWeN[0]) begin
        rise0 <= rise0 + 1;
        if (rstN[0] && !ramCeN[0]) mem0[ramA[0]] <= ramDi[0];
    end

    // SRAM 1 commits on the rising edge of WE_N.
    always @(posedge ramWeN[1]) begin
        if (rstN[1] && !ramCeN[1]) mem1[ramA[1]] <= ramDi[1];
    end

    assign ramDo[0] = mem0[ramA[0]] ^ {48'd0, badBit[ramA[0]]};
    assign ramDo[1] = mem1[ramA[1]];

    iram_loader u_dut0 (
        .clk      (clk),
        .reset_n  (rstN[0]),
        .in_valid (inValid[0]),
        .in_ready (inReady[0]),
        .in_addr  (inAddr[0]),
        .in_data  (inData[0]),
        .ram_a    (ramA[0]),
        .ram_di   (ramDi[0]),
        .ram_do   (ramDo[0]),
        .ram_ce_n (ramCeN[0]),
        .ram_we_n (ramWeN[0]),
        .busy     (busy[0]),
        .err_clr  (errClr[0]),
        .err      (err[0]),
        .err_addr (errAddr[0]),
        .word_cnt (wordCnt[0])
    );

    iram_loader #(
        .SETUP_CYC (S1),
        .PULSE_CYC (P1),
        .HOLD_CYC  (H1),
        .VERIFY    (1'b0)
    ) u_dut1 (
        .clk      (clk),
        .reset_n  (rstN[1]),
        .in_valid (inValid[1]),
        .in_ready (inReady[1]),
        .in_addr  (inAddr[1]),
        .in_data  (inData[1]),
        .ram_a    (ramA[1]),
        .ram_di   (ramDi[1]),
        .ram_do   (ramDo[1]),
        .ram_ce_n (ramCeN[1]),
        .ram_we_n (ramWeN[1]),
        .busy     (busy[1]),
        .err_clr  (errClr[1]),
        .err      (err[1]),
        .err_addr (errAddr[1]),
        .word_cnt (wordCnt[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkStatus(input int sel);
        checkOutput("wordCnt", 64'(wordCnt[sel]), 64'(cntM[sel]));
        if (sel == 0) begin
            checkOutput("err", 64'(err[0]), 64'(errM));
            checkOutput("errAddr", 64'(errAddr[0]), 64'(errAddrM));
        end else begin
            checkOutput("err1", 64'(err[1]), 64'd0);
            checkOutput("errAddr1", 64'(errAddr[1]), 64'd0);
        end
    endtask

    // One write on instance sel; clrAt pulses err_clr in that cycle after
    // acceptance, abortK asserts reset in that cycle instead of completing.
    task automatic applyStimulus(input int sel, input logic [13:0] a, input logic [48:0] d,
                                 input int clrAt, input int abortK);
        int n, k, weFirst, weCnt, ceCnt, busyLow, heldBad, kReady, sp, pp;
        bit mism;
        logic [48:0] got;
        kReady = (sel == 0) ? 1 + S0 + P0 + H0 + V0 : 1 + S1 + P1 + H1 + V1;
        sp = (sel == 0) ? S0 : S1;
        pp = (sel == 0) ? P0 : P1;
        @(negedge clk);
        inValid[sel] = 1'b1;
        inAddr[sel]  = a;
        inData[sel]  = d;
        n = 0;
        while (!inReady[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checkOutput("acceptTimeout", 64'd0, 64'd1);
            inValid[sel] = 1'b0;
            return;
        end
        @(negedge clk);
        inValid[sel] = 1'b0;
        inAddr[sel]  = ~a;
        inData[sel]  = ~d;
        k = 1; weFirst = 0; weCnt = 0; ceCnt = 0; busyLow = 0; heldBad = 0;
        while (!inReady[sel] && k < 60) begin
            if (k == abortK) begin
                rstN[sel] = 1'b0;
                #1;
                checkOutput("abortWeN", 64'(ramWeN[sel]), 64'd1);
                checkOutput("abortCeN", 64'(ramCeN[sel]), 64'd1);
                checkOutput("abortBusy", 64'(busy[sel]), 64'd0);
                checkOutput("abortReady", 64'(inReady[sel]), 64'd1);
                checkOutput("abortCnt", 64'(wordCnt[sel]), 64'd0);
                @(negedge clk);
                rstN[sel] = 1'b1;
                cntM[sel] = 16'd0;
                if (sel == 0) begin
                    errM = 1'b0;
                    errAddrM = 14'd0;
                end
                return;
            end
            if (!ramWeN[sel]) begin
                weCnt++;
                if (weFirst == 0) weFirst = k;
            end
            if (!ramCeN[sel]) ceCnt++;
            if (!busy[sel]) busyLow++;
            if (ramA[sel] !== a || ramDi[sel] !== d) heldBad++;
            errClr[sel] = (k == clrAt);
            @(negedge clk);
            k++;
        end
        errClr[sel] = 1'b0;

        checkOutput("readyLatency", 64'(k), 64'(kReady));
        checkOutput("weFirst", 64'(weFirst), 64'(1 + sp));
        checkOutput("weLowCycles", 64'(weCnt), 64'(pp));
        checkOutput("ceLowCycles", 64'(ceCnt), 64'(kReady - 1));
        checkOutput("busyGaps", 64'(busyLow), 64'd0);
        checkOutput("addrDataHeld", 64'(heldBad), 64'd0);
        checkOutput("idleBusy", 64'(busy[sel]), 64'd0);
        checkOutput("idleCeN", 64'(ramCeN[sel]), 64'd1);

        cntM[sel] = cntM[sel] + 16'd1;
        if (sel == 0) begin
            expMem0[int'(a)] = d;
            got = mem0[a];
            mism = badBit[a];
            if (clrAt != 0 && clrAt != VK0) begin
                errM = 1'b0;
                errAddrM = 14'd0;
            end
            if (mism) begin
                if (!errM || clrAt == VK0) errAddrM = a;
                errM = 1'b1;
            end else if (clrAt == VK0) begin
                errM = 1'b0;
                errAddrM = 14'd0;
            end
        end else begin
            expMem1[int'(a)] = d;
            got = mem1[a];
        end
        checkOutput("memCommit", 64'(got), 64'(d));
        checkStatus(sel);
    endtask

    task automatic clearErr();
        @(negedge clk);
        errClr[0] = 1'b1;
        @(negedge clk);
        errClr[0] = 1'b0;
        errM = 1'b0;
        errAddrM = 14'd0;
        checkStatus(0);
    endtask

    function automatic logic [48:0] randWord();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[48:0];
    endfunction

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stamp [4];
        int n, r, rBase;
        logic [13:0] a;
        logic [48:0] d;

        rstN = 2'b00; inValid = 2'b00; errClr = 2'b00;
        inAddr[0] = '0; inAddr[1] = '0; inData[0] = '0; inData[1] = '0;
        cntM[0] = 16'd0; cntM[1] = 16'd0; errM = 1'b0; errAddrM = 14'd0;
        repeat (3) @(negedge clk);
        rstN = 2'b11;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            checkOutput("rstReady", 64'(inReady[s]), 64'd1);
            checkOutput("rstBusy", 64'(busy[s]), 64'd0);
            checkOutput("rstCeN", 64'(ramCeN[s]), 64'd1);
            checkOutput("rstWeN", 64'(ramWeN[s]), 64'd1);
            checkOutput("rstA", 64'(ramA[s]), 64'd0);
            checkOutput("rstDi", 64'(ramDi[s]), 64'd0);
            checkStatus(s);
        end

        $display("[TB] single write");
        applyStimulus(0, 14'o00017, 49'h1_2345_6789_ABCD, 0, 0);

        $display("[TB] back-to-back writes");
        rBase = rise0;
        @(negedge clk);
        inValid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inAddr[0] = 14'(i);
            inData[0] = randWord();
            expMem0[i] = inData[0];
            n = 0;
            while (!inReady[0] && n < 50) begin
                @(negedge clk);
                n++;
            end
            stamp[i] = cyc;
            @(negedge clk);
            cntM[0] = cntM[0] + 16'd1;
            if (i > 0) checkOutput("b2bSpacing", 64'(stamp[i] - stamp[i-1]), 64'd6);
        end
        inValid[0] = 1'b0;
        n = 0;
        while (!inReady[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2bWeRises", 64'(rise0 - rBase), 64'd4);
        checkStatus(0);
        for (int i = 0; i < 4; i++) checkOutput("b2bMem", 64'(mem0[i]), 64'(expMem0[i]));

        $display("[TB] verify mismatch with first-error capture");
        badBit[100] = 1'b1;
        badBit[200] = 1'b1;
        applyStimulus(0, 14'd100, randWord(), 0, 0);
        applyStimulus(0, 14'd200, randWord(), 0, 0);
        clearErr();

        $display("[TB] mismatch coinciding with err_clr");
        badBit[7] = 1'b1;
        applyStimulus(0, 14'd100, randWord(), 0, 0);
        applyStimulus(0, 14'd7, randWord(), VK0, 0);

        $display("[TB] reset during pulse");
        applyStimulus(0, 14'd50, randWord(), 0, 1 + S0 + 1);
        applyStimulus(0, 14'd51, randWord(), 0, 0);

        $display("[TB] randomized writes");
        for (int i = 0; i < 20; i++) begin
            a = 14'($urandom_range(0, 16383));
            d = randWord();
            if ($urandom_range(0, 4) == 0) badBit[a] = 1'b1;
            r = int'($urandom_range(0, 3));
            applyStimulus(0, a, d, (r == 0) ? VK0 : ((r == 1) ? 1 : 0), 0);
        end

        $display("[TB] slow-setup instance without read-back");
        applyStimulus(1, 14'd16383, randWord(), 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 14'($urandom_range(0, 16383)), randWord(), 0, 0);
        end

        foreach (expMem0[key]) checkOutput("mem0Final", 64'(mem0[key]), 64'(expMem0[key]));
        foreach (expMem1[key]) checkOutput("mem1Final", 64'(mem1[key]), 64'(expMem1[key]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
